// File: rtl/fft_pkg.sv
// Shared FFT constants, occupancy state type and the 5-bit bit-reverse helper.
package fft_pkg;

  localparam int unsigned FFT_POINTS = 32;
  localparam int unsigned INDEX_BITS = 5;

  typedef enum logic [1:0] {
    StEmpty,
    StOne,
    StTwo
  } occ_state_e;

  function automatic logic [INDEX_BITS-1:0] rev5(input logic [INDEX_BITS-1:0] k);
    return {k[0], k[1], k[2], k[3], k[4]};
  endfunction

endpackage

// File: rtl/fft_output_serializer_if.sv
// Frame-in / stream-out signal bundle; master is the serializer, slave its environment.
interface fft_output_serializer_if #(
  parameter int unsigned p_dataBits = 28,
  parameter int unsigned p_points   = 32
);

  logic [p_points-1:0][p_dataBits-1:0] i_c;
  logic                                i_valid;
  logic                                o_in_ready;
  logic                                o_overflow;
  logic [p_dataBits-1:0]               o_data;
  logic [4:0]                          o_index;
  logic                                o_valid;
  logic                                o_last;
  logic                                i_ready;

  modport master (
    input  i_c, i_valid, i_ready,
    output o_in_ready, o_overflow, o_data, o_index, o_valid, o_last
  );

  modport slave (
    output i_c, i_valid, i_ready,
    input  o_in_ready, o_overflow, o_data, o_index, o_valid, o_last
  );

endinterface

// File: rtl/fft_frame_bank.sv
// One frame of stage results: write-all in one cycle, indexed combinational read.
module fft_frame_bank
  import fft_pkg::*;
#(
  parameter int unsigned p_dataBits = 28,
  parameter int unsigned p_points   = FFT_POINTS
) (
  input  logic                                CLK,
  input  logic                                RST,
  input  logic                                we,
  input  logic [p_points-1:0][p_dataBits-1:0] wdata,
  input  logic [INDEX_BITS-1:0]               raddr,
  output logic [p_dataBits-1:0]               rdata
);

  logic [p_points-1:0][p_dataBits-1:0] mem_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      mem_q <= '0;
    end else if (we) begin
      mem_q <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/fft_output_serializer.sv
// Ping-pong capture of a 32-point stage frame, streamed out one word per valid/ready beat.
module fft_output_serializer
  import fft_pkg::*;
#(
  parameter int unsigned p_dataBits   = 28,
  parameter int unsigned p_points     = FFT_POINTS,
  parameter bit          p_bitReverse = 1'b1
) (
  input  logic                    CLK,
  input  logic                    RST,
  fft_output_serializer_if.master bus
);

  occ_state_e            state_q, state_d;
  logic                  wr_ptr_q, rd_ptr_q, overflow_q;
  logic [INDEX_BITS-1:0] cnt_q, rd_addr;
  logic                  in_ready, out_valid, capture, beat, frame_done;
  logic [p_dataBits-1:0] rdata0, rdata1;

  assign in_ready   = (state_q != StTwo);
  assign out_valid  = (state_q != StEmpty);
  assign capture    = bus.i_valid && in_ready;
  assign beat       = out_valid && bus.i_ready;
  assign frame_done = beat && (cnt_q == INDEX_BITS'(FFT_POINTS - 1));

  // Capture and release in the same cycle cancel out; a bank freed now is not reused now.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StEmpty: if (capture) state_d = StOne;
      StOne: begin
        if (capture && !frame_done) state_d = StTwo;
        else if (!capture && frame_done) state_d = StEmpty;
      end
      StTwo:   if (frame_done) state_d = StOne;
      default: state_d = StEmpty;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= StEmpty;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      cnt_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      overflow_q <= bus.i_valid && !in_ready;
      if (capture)    wr_ptr_q <= ~wr_ptr_q;
      if (frame_done) rd_ptr_q <= ~rd_ptr_q;
      if (beat)       cnt_q    <= cnt_q + 1'b1;
    end
  end

  assign rd_addr = p_bitReverse ? rev5(cnt_q) : cnt_q;

  fft_frame_bank #(
    .p_dataBits (p_dataBits),
    .p_points   (p_points)
  ) u_bank0 (
    .CLK   (CLK),
    .RST   (RST),
    .we    (capture && !wr_ptr_q),
    .wdata (bus.i_c),
    .raddr (rd_addr),
    .rdata (rdata0)
  );

  fft_frame_bank #(
    .p_dataBits (p_dataBits),
    .p_points   (p_points)
  ) u_bank1 (
    .CLK   (CLK),
    .RST   (RST),
    .we    (capture && wr_ptr_q),
    .wdata (bus.i_c),
    .raddr (rd_addr),
    .rdata (rdata1)
  );

  assign bus.o_in_ready = in_ready;
  assign bus.o_overflow = overflow_q;
  assign bus.o_valid    = out_valid;
  assign bus.o_index    = cnt_q;
  assign bus.o_data     = rd_ptr_q ? rdata1 : rdata0;
  assign bus.o_last     = out_valid && (cnt_q == INDEX_BITS'(FFT_POINTS - 1));

endmodule

// File: tb/tb_fft_output_serializer.sv
// Scoreboard bench: natural-order and bit-reversed serializers driven with identical stimulus.
module tb_fft_output_serializer;

  localparam int DW = 28;

  typedef struct {
    logic [DW-1:0] data;
    logic [4:0]    index;
  } exp_t;

  logic                 clk, rst, iv, ir, sel;
  logic [31:0][DW-1:0]  c;
  exp_t                 sb[$];
  int                   tests, fails;

  fft_output_serializer_if #(.p_dataBits(DW), .p_points(32)) if0 ();
  fft_output_serializer_if #(.p_dataBits(DW), .p_points(32)) if1 ();

  assign if0.i_c = c;
  assign if0.i_valid = iv;
  assign if0.i_ready = ir;
  assign if1.i_c = c;
  assign if1.i_valid = iv;
  assign if1.i_ready = ir;

  fft_output_serializer #(.p_dataBits(DW), .p_points(32), .p_bitReverse(1'b0)) u_nat (
    .CLK (clk),
    .RST (rst),
    .bus (if0.master)
  );

  fft_output_serializer #(.p_dataBits(DW), .p_points(32), .p_bitReverse(1'b1)) u_rev (
    .CLK (clk),
    .RST (rst),
    .bus (if1.master)
  );

  wire [DW-1:0] odata    = sel ? if1.o_data : if0.o_data;
  wire [4:0]    oindex   = sel ? if1.o_index : if0.o_index;
  wire          ovalid   = sel ? if1.o_valid : if0.o_valid;
  wire          olast    = sel ? if1.o_last : if0.o_last;
  wire          oinready = sel ? if1.o_in_ready : if0.o_in_ready;
  wire          oovf     = sel ? if1.o_overflow : if0.o_overflow;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [4:0] brev(input int k);
    logic [4:0] v;
    v = 5'(k);
    return {v[0], v[1], v[2], v[3], v[4]};
  endfunction

  // Expected stream for the currently selected DUT.
  task automatic push_frame();
    exp_t e;
    for (int k = 0; k < 32; k++) begin
      e.data  = sel ? c[brev(k)] : c[k];
      e.index = 5'(k);
      sb.push_back(e);
    end
  endtask

  task automatic random_frame();
    for (int k = 0; k < 32; k++) c[k] = DW'($urandom);
  endtask

  task automatic drain(input int nbeats, input bit alt, input bit nogap);
    int popped = 0;
    int cyc = 0;
    bit hold = 0;
    logic [DW-1:0] hd;
    logic [4:0] hi;
    exp_t e;
    while (popped < nbeats && cyc < 400) begin
      ir = alt ? ~cyc[0] : 1'b1;
      if (hold) begin
        tests++;
        if (odata !== hd || oindex !== hi) begin
          fails++;
          $display("FAIL hold: data=%0h index=%0d, required data=%0h index=%0d", odata, oindex, hd,
                   hi);
        end
      end
      hold = 0;
      if (ovalid && ir) begin
        tests++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL extra_beat: data=%0h index=%0d, required no beat", odata, oindex);
        end else begin
          e = sb.pop_front();
          if (odata !== e.data || oindex !== e.index || olast !== (e.index == 5'd31)) begin
            fails++;
            $display("FAIL beat: data=%0h index=%0d last=%0b, required data=%0h index=%0d last=%0b",
                     odata, oindex, olast, e.data, e.index, e.index == 5'd31);
          end
        end
        popped++;
      end else if (ovalid) begin
        hold = 1;
        hd = odata;
        hi = oindex;
      end else if (nogap && popped > 0) begin
        tests++;
        fails++;
        $display("FAIL gap: o_valid=0 after %0d beats, required 1", popped);
      end
      step();
      cyc++;
    end
    if (popped < nbeats) begin
      tests++;
      fails++;
      $display("FAIL timeout: %0d beats, required %0d", popped, nbeats);
    end
  endtask

  task automatic check_idle(input string name);
    tests++;
    if (ovalid !== 1'b0 || oinready !== 1'b1 || olast !== 1'b0) begin
      fails++;
      $display("FAIL %s: valid=%0b in_ready=%0b last=%0b, required 0 1 0", name, ovalid, oinready,
               olast);
    end
  endtask

  task automatic capture_one();
    iv = 1'b1;
    push_frame();
    step();
    iv = 1'b0;
    tests++;
    if (ovalid !== 1'b1 || oindex !== 5'd0) begin
      fails++;
      $display("FAIL latency: valid=%0b index=%0d, required 1 0", ovalid, oindex);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    iv = 1'b1;
    ir = 1'b1;
    for (int i = 0; i < 5; i++) begin
      random_frame();
      step();
      tests++;
      if (if0.o_valid !== 1'b0 || if0.o_in_ready !== 1'b1 || if0.o_overflow !== 1'b0 ||
          if0.o_data !== '0 || if0.o_index !== 5'd0 || if1.o_valid !== 1'b0 ||
          if1.o_in_ready !== 1'b1 || if1.o_data !== '0) begin
        fails++;
        $display("FAIL reset: valid=%0b in_ready=%0b ovf=%0b data=%0h, required 0 1 0 0",
                 if0.o_valid, if0.o_in_ready, if0.o_overflow, if0.o_data);
      end
    end
    rst = 1'b0;
    iv = 1'b0;
    step();
    check_idle("reset_release");
  endtask

  task automatic test_natural();
    sel = 1'b0;
    ir = 1'b1;
    for (int k = 0; k < 32; k++) c[k] = DW'(k + 1);
    capture_one();
    drain(32, 1'b0, 1'b1);
    check_idle("natural_end");
  endtask

  task automatic test_bit_reverse();
    sel = 1'b1;
    ir = 1'b1;
    for (int k = 0; k < 32; k++) c[k] = DW'(k + 1);
    capture_one();
    tests++;
    if (odata !== DW'(1)) begin
      fails++;
      $display("FAIL rev_first: data=%0d, required 1", odata);
    end
    step();
    tests++;
    if (odata !== DW'(17) || oindex !== 5'd1) begin
      fails++;
      $display("FAIL rev_second: data=%0d index=%0d, required 17 1", odata, oindex);
    end
    void'(sb.pop_front());
    drain(31, 1'b0, 1'b1);
    check_idle("rev_end");
  endtask

  task automatic test_backpressure();
    sel = 1'b1;
    ir = 1'b0;
    random_frame();
    capture_one();
    drain(32, 1'b1, 1'b0);
    ir = 1'b1;
    check_idle("bp_end");
  endtask

  task automatic test_back_to_back();
    sel = 1'b1;
    ir = 1'b0;
    iv = 1'b1;
    random_frame();
    push_frame();
    step();
    tests++;
    if (oinready !== 1'b1) begin
      fails++;
      $display("FAIL after_a: in_ready=%0b, required 1", oinready);
    end
    random_frame();
    push_frame();
    step();
    tests++;
    if (oinready !== 1'b0 || oovf !== 1'b0) begin
      fails++;
      $display("FAIL after_b: in_ready=%0b ovf=%0b, required 0 0", oinready, oovf);
    end
    random_frame();
    step();
    iv = 1'b0;
    tests++;
    if (oovf !== 1'b1) begin
      fails++;
      $display("FAIL overflow: ovf=%0b, required 1", oovf);
    end
    step();
    tests++;
    if (oovf !== 1'b0 || ovalid !== 1'b1 || oindex !== 5'd0) begin
      fails++;
      $display("FAIL overflow_pulse: ovf=%0b valid=%0b index=%0d, required 0 1 0", oovf, ovalid,
               oindex);
    end
    drain(64, 1'b0, 1'b1);
    check_idle("b2b_end");
  endtask

  task automatic test_reset_mid();
    sel = 1'b1;
    ir = 1'b1;
    random_frame();
    capture_one();
    drain(10, 1'b0, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    sb.delete();
    tests++;
    if (ovalid !== 1'b0 || oinready !== 1'b1 || oindex !== 5'd0) begin
      fails++;
      $display("FAIL mid_reset: valid=%0b in_ready=%0b index=%0d, required 0 1 0", ovalid, oinready,
               oindex);
    end
    random_frame();
    capture_one();
    drain(32, 1'b0, 1'b1);
    check_idle("mid_reset_end");
  endtask

  initial begin
    tests = 0;
    fails = 0;
    sel = 1'b0;
    rst = 1'b1;
    iv = 1'b0;
    ir = 1'b0;
    c = '0;
    test_reset();
    test_natural();
    test_bit_reverse();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
